cpu4_prog_mem: RTL and testbench

//   64 x 4-bit program/data memory that sits between the 4-bit nibble CPU's

---
 rtl/cpu4_pkg.sv | 18 +
 rtl/cpu4_prog_mem_if.sv | 30 +++
 rtl/cpu4_mem_array.sv | 30 +++
 rtl/cpu4_prog_mem.sv | 119 +++++++++++
 tb/tb_cpu4_prog_mem.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit nibble CPU slice: bus widths, memory-controller
// FSM states and the CPU bus-phase encoding.
package cpu4_pkg;

  localparam int unsigned CPU4_ADDR_W = 6;
  localparam int unsigned CPU4_DATA_W = 4;

  // cpu_wcyc encoding: address phase vs. write-back data phase
  localparam logic CPU4_PHASE_ADDR  = 1'b0;
  localparam logic CPU4_PHASE_WDATA = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } mem_state_e;

endpackage

// File: rtl/cpu4_prog_mem_if.sv
// Loader and CPU bus bundle for cpu4_prog_mem; master drives loader/CPU side,
// slave is the memory.
interface cpu4_prog_mem_if
  import cpu4_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU4_ADDR_W,
  parameter int unsigned DATA_W = CPU4_DATA_W
);

  logic              prog_en;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              prog_done;
  logic [ADDR_W-1:0] cpu_bus;
  logic              cpu_wcyc;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_hold;

  modport master (
    output prog_en, prog_valid, prog_data, cpu_bus, cpu_wcyc,
    input  prog_ready, prog_done, cpu_data, cpu_hold
  );

  modport slave (
    input  prog_en, prog_valid, prog_data, cpu_bus, cpu_wcyc,
    output prog_ready, prog_done, cpu_data, cpu_hold
  );

endinterface

// File: rtl/cpu4_mem_array.sv
// DEPTH x DATA_W flop array: async clear, one synchronous write port,
// one combinational read port (read returns the pre-write value).
module cpu4_mem_array #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu4_prog_mem.sv
// Program/data memory for the nibble CPU: streaming loader that holds the CPU
// in reset while filling memory, plus the CPU address-latch / write-back path.
module cpu4_prog_mem
  import cpu4_pkg::*;
#(
  parameter int unsigned ADDR_W   = CPU4_ADDR_W,
  parameter int unsigned DATA_W   = CPU4_DATA_W,
  parameter int          PROT_TOP = 0
) (
  input logic            clk,
  input logic            rst_p,
  cpu4_prog_mem_if.slave bus
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              armed_q, armed_d;
  logic              ready_q;
  logic              hold_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_wr_ok;

  // Signed compare keeps PROT_TOP = 0 from being a constant-true unsigned test
  assign cpu_wr_ok = (int'(addr_q) >= PROT_TOP);

  // Next-state, loader counter, address latch and write-port steering
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    done_d    = done_q;
    armed_d   = armed_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = bus.cpu_bus[DATA_W-1:0];

    unique case (state_q)
      ST_RUN: begin
        if (bus.cpu_wcyc == CPU4_PHASE_ADDR) begin
          addr_d = bus.cpu_bus;
        end else if (cpu_wr_ok) begin
          mem_we = 1'b1;
        end
        // Load entry is edge-armed: prog_en must be seen low in RUN first
        if (!bus.prog_en) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
          armed_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (!bus.prog_en) state_d = ST_FLUSH;
        if (ready_q && bus.prog_valid) begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = bus.prog_data;
          cnt_d     = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d = ST_FLUSH;
            done_d  = 1'b1;
          end
        end
      end

      ST_FLUSH: state_d = ST_RUN;

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      armed_q <= armed_d;
      ready_q <= (state_d == ST_LOAD);
      hold_q  <= (state_d != ST_RUN);
    end
  end

  cpu4_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst_p (rst_p),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (bus.cpu_bus),
    .rdata (mem_rdata)
  );

  assign bus.prog_ready = ready_q;
  assign bus.prog_done  = done_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.cpu_data   = (bus.cpu_wcyc == CPU4_PHASE_WDATA) ? '0 : mem_rdata;

endmodule

// File: tb/tb_cpu4_prog_mem.sv
// Directed bench for cpu4_prog_mem: full/gapped/aborted loads, CPU writes,
// write protection on a second instance, and reset during load.
module tb_cpu4_prog_mem;
  import cpu4_pkg::*;

  logic clk;
  logic rst_p;
  int   n_run;
  int   n_fail;

  cpu4_prog_mem_if b0 ();
  cpu4_prog_mem_if b1 ();

  cpu4_prog_mem #(.PROT_TOP(0)) u_dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (b0.slave)
  );

  cpu4_prog_mem #(.PROT_TOP(32)) u_prot (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input string tag, input logic [5:0] a, input logic [3:0] exp);
    b0.cpu_wcyc = 1'b0;
    b0.cpu_bus  = a;
    #1;
    check(tag, 32'(b0.cpu_data), 32'(exp));
  endtask

  // Streams beats into b0 from the cycle prog_en is raised; data = (beat+ofs)%16
  task automatic do_load(input int beats, input bit toggle, input int ofs);
    int acc = 0;
    int cyc = 0;
    int hold_bad = 0;
    b0.prog_en = 1'b1;
    tick();
    check("hold_enter", 32'(b0.cpu_hold), 32'd1);
    check("ready_enter", 32'(b0.prog_ready), 32'd1);
    while (acc < beats && cyc < 400) begin
      b0.prog_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      b0.prog_data  = 4'((acc + ofs) % 16);
      tick();
      if (b0.prog_valid) acc++;
      cyc++;
      if (b0.cpu_hold !== 1'b1) hold_bad++;
    end
    b0.prog_valid = 1'b0;
    check("beats_accepted", 32'(acc), 32'(beats));
    check("hold_throughout", 32'(hold_bad), 32'd0);
  endtask

  typedef struct {
    logic [5:0] addr;
    logic [3:0] wdat;
    logic [3:0] exp;
  } prot_vec_t;

  initial begin
    prot_vec_t pv [3];
    pv[0] = '{6'h10, 4'h7, 4'h0};
    pv[1] = '{6'h1F, 4'h3, 4'h0};
    pv[2] = '{6'h20, 4'h9, 4'h9};

    n_run = 0;
    n_fail = 0;
    rst_p = 1'b1;
    b0.prog_en = 1'b0; b0.prog_valid = 1'b0; b0.prog_data = '0;
    b0.cpu_bus = '0;   b0.cpu_wcyc = 1'b0;
    b1.prog_en = 1'b0; b1.prog_valid = 1'b0; b1.prog_data = '0;
    b1.cpu_bus = '0;   b1.cpu_wcyc = 1'b0;
    tick();
    tick();
    check("rst_hold", 32'(b0.cpu_hold), 32'd0);
    check("rst_ready", 32'(b0.prog_ready), 32'd0);
    check("rst_done", 32'(b0.prog_done), 32'd0);
    check("rst_data", 32'(b0.cpu_data), 32'd0);
    rst_p = 1'b0;
    tick();

    // 1: full load, valid every cycle
    do_load(64, 1'b0, 0);
    check("t1_done", 32'(b0.prog_done), 32'd1);
    check("t1_ready_flush", 32'(b0.prog_ready), 32'd0);
    check("t1_hold_flush", 32'(b0.cpu_hold), 32'd1);
    tick();
    check("t1_hold_run", 32'(b0.cpu_hold), 32'd0);
    rd0("t1_mem25", 6'h25, 4'h5);
    rd0("t1_mem3f", 6'h3F, 4'hF);
    tick(); tick(); tick();
    check("t1_no_reentry", 32'(b0.cpu_hold), 32'd0);
    check("t1_done_sticky", 32'(b0.prog_done), 32'd1);
    b0.prog_en = 1'b0;
    tick();

    // 2: valid toggling 1/0
    do_load(64, 1'b1, 7);
    check("t2_done", 32'(b0.prog_done), 32'd1);
    b0.prog_en = 1'b0;
    tick();
    check("t2_hold_run", 32'(b0.cpu_hold), 32'd0);
    rd0("t2_mem3f", 6'h3F, 4'h6);
    rd0("t2_mem0a", 6'h0A, 4'h1);
    rd0("t2_mem00", 6'h00, 4'h7);
    tick();

    // 3: abort after 10 beats
    do_load(10, 1'b0, 2);
    b0.prog_en = 1'b0;
    tick();
    check("t3_hold_1cyc", 32'(b0.cpu_hold), 32'd1);
    check("t3_done", 32'(b0.prog_done), 32'd0);
    tick();
    check("t3_hold_2cyc", 32'(b0.cpu_hold), 32'd0);
    rd0("t3_mem00", 6'h00, 4'h2);
    rd0("t3_mem09", 6'h09, 4'hB);
    rd0("t3_mem0a", 6'h0A, 4'h1);
    tick();

    // 4: CPU write-back through the address latch
    b0.cpu_bus = 6'h30; b0.cpu_wcyc = 1'b0;
    tick();
    b0.cpu_bus = 6'h0A; b0.cpu_wcyc = 1'b1;
    #1;
    check("t4_data_wcyc", 32'(b0.cpu_data), 32'd0);
    tick();
    rd0("t4_mem30", 6'h30, 4'hA);
    b0.cpu_bus = 6'h00; b0.cpu_wcyc = 1'b0;
    tick();
    b0.cpu_bus = 6'h03; b0.cpu_wcyc = 1'b1;
    tick();
    rd0("t4_mem00_unprot", 6'h00, 4'h3);

    // 5: protection below 32 on the second instance
    foreach (pv[i]) begin
      b1.cpu_bus = pv[i].addr; b1.cpu_wcyc = 1'b0;
      tick();
      b1.cpu_bus = 6'(pv[i].wdat); b1.cpu_wcyc = 1'b1;
      tick();
      b1.cpu_bus = pv[i].addr; b1.cpu_wcyc = 1'b0;
      #1;
      check($sformatf("t5_prot_%0h", pv[i].addr), 32'(b1.cpu_data), 32'(pv[i].exp));
    end

    // 6: reset during load
    do_load(20, 1'b0, 4);
    rd0("t6_mem00_pre", 6'h00, 4'h4);
    b0.prog_valid = 1'b1;
    rst_p = 1'b1;
    #1;
    check("t6_hold_async", 32'(b0.cpu_hold), 32'd0);
    check("t6_ready_async", 32'(b0.prog_ready), 32'd0);
    rd0("t6_mem00", 6'h00, 4'h0);
    rd0("t6_mem30", 6'h30, 4'h0);
    tick();
    rst_p = 1'b0;
    tick(); tick(); tick();
    check("t6_no_reentry_hold", 32'(b0.cpu_hold), 32'd0);
    check("t6_no_reentry_ready", 32'(b0.prog_ready), 32'd0);
    b0.prog_valid = 1'b0;
    rd0("t6_mem13", 6'h13, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
